// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, fetches words over req/ack, presents
// them downstream under valid/ready, and applies datapath redirects with squashing.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        addr_err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] target_q, target_d;
  logic        squash_q, squash_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] redir_pc;

  assign redir_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      target_q   <= RESET_PC;
      squash_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      target_q   <= target_d;
      squash_q   <= squash_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    target_d   = target_q;
    squash_d   = squash_q;
    addr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        fetch_pc_d = RESET_PC;
      end
      REQ: begin
        if (redirect) begin
          addr_err_d = |redirect_pc[1:0];
          if (imem_ack) begin
            fetch_pc_d = redir_pc;
            squash_d   = 1'b0;
          end else begin
            // Outstanding request must stay put; remember where to go once it returns.
            squash_d = 1'b1;
            target_d = redir_pc;
          end
        end else if (imem_ack) begin
          if (squash_q) begin
            fetch_pc_d = target_q;
            squash_d   = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          addr_err_d = |redirect_pc[1:0];
          fetch_pc_d = redir_pc;
          state_d    = REQ;
        end else if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == REQ);
    instr_valid = (state_q == HOLD);
    imem_addr   = fetch_pc_q;
    instr       = instr_q;
    opcode      = instr_q[31:26];
    funct       = instr_q[5:0];
    pc          = pc_q;
    retired     = retired_q;
    addr_err    = addr_err_q;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that feeds the opcode/funct fields to the control unit. It holds the PC and issues word requests to instruction memory over a req/ack handshake. It presents each fetched instruction downstream under valid/ready and applies branch/jump redirects from the datapath, discarding wrong-path fetches. It also keeps a free-running count of instructions accepted downstream.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch byte address, word aligned
- imem_ack  input  1  memory has returned imem_rdata this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- instr_valid  output  1  instr/pc hold a valid instruction
- instr_ready  input  1  downstream accepts instruction this cycle
- instr  output  32  fetched instruction
- opcode  output  6  instr[31:26], to control unit
- funct  output  6  instr[5:0], to ALU control
- pc  output  32  address of instr
- redirect  input  1  branch taken / jump / jr this cycle
- redirect_pc  input  32  new fetch address
- addr_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0
- retired  output  32  count of accepted instructions

## Operation
- States: IDLE, REQ, HOLD.
- Transfer rules:
  - Memory transfer: imem_req & imem_ack.
  - Downstream transfer: instr_valid & instr_ready.
- IDLE: entered only from reset. Goes to REQ on the next edge; fetch_pc = RESET_PC.
- REQ:
  - imem_req=1 and imem_addr=fetch_pc.
  - imem_addr must not change while imem_req=1 and ack is absent.
  - On ack with no squash pending: latch imem_rdata into instr, pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32), go to HOLD.
- HOLD:
  - instr_valid=1; imem_req=0.
  - On downstream transfer: retired<=retired+1 (wraps), go to REQ.
- Redirect (priority over all normal transitions):
  - In HOLD: the held instruction is dropped, with no retired increment even if instr_ready=1 the same cycle. fetch_pc<=redirect_pc, go to REQ.
  - In REQ with imem_ack=1 the same cycle: returned data is discarded, fetch_pc<=redirect_pc, stay in REQ.
  - In REQ without ack: the outstanding request is kept unchanged. Set squash_pending and store redirect_pc. When the ack arrives, the data is discarded, fetch_pc<=stored target, squash_pending cleared, stay in REQ.
  - A later redirect while squash_pending=1 overwrites the stored target.
  - Redirect in IDLE is ignored.
- Misaligned redirect_pc: bits [1:0] are forced to 0, the redirect proceeds, and addr_err pulses for one cycle.
- opcode and funct are combinational slices of the instr register.

## Timing
- Reset values:
  - Control and data outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, funct=0.
  - pc=RESET_PC, addr_err=0, retired=0, squash_pending=0.
- imem_req first goes high on the first rising edge after rst_n deasserts.
- Memory may ack in the same cycle as the request (0-wait) or any number of cycles later.
- Ack in cycle N: instr_valid=1 from cycle N+1.
- Downstream transfer in cycle M: imem_req=1 in cycle M+1 with the next address.
- Peak rate is 1 instruction per 2 cycles with 0-wait memory.
- instr, pc and instr_valid are stable while instr_valid=1 and instr_ready=0.
- imem_ack while imem_req=0 is ignored.
- rst_n asserted mid-transaction immediately forces all reset values. Any in-flight request is abandoned and its late ack is ignored.

## Test plan
- Reset release, 0-wait memory, instr_ready=1 constant:
  - imem_addr sequence is 0x0, 0x4, 0x8, with imem_req high every other cycle.
  - opcode goes 000000 (0x00000020), 100011 (0x8C010000), 101011 (0xAC010004).
  - retired reaches 3.
- 3-cycle ack latency, instr_ready low for 4 cycles in HOLD:
  - imem_addr is held stable throughout the wait.
  - instr, pc and instr_valid stay constant while stalled.
  - Next request is issued 1 cycle after ready rises.
- Redirect to 0x40 in HOLD with instr_ready=1 in the same cycle:
  - Instruction dropped, retired unchanged.
  - Next imem_addr=0x40.
- Redirect to 0x80 two cycles before a delayed ack, then a second redirect to 0x100:
  - Ack data discarded, no instr_valid.
  - Next request goes to 0x100.
- Redirect to 0x42:
  - addr_err pulses for one cycle.
  - Next imem_addr=0x40.
- rst_n pulsed low while in REQ with an ack pending:
  - All outputs return to reset values in the same cycle.
  - A later stray ack produces no instr_valid.
